// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking, baud constants and the TX state encoding.
// The RX block is expected to import the same package.
package uart_pkg;

   localparam int unsigned UART_CLK_HZ   = 12_000_000;
   localparam int unsigned UART_BIT_RATE = 115_200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // Integer truncation is intentional: the residual baud error is tolerated by 8N1 receivers.
   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_tx_unit.sv
// 8N1 LSB-first serial transmitter; txd falls and busy rises on the edge that accepts en.
// Requests are ignored while busy; en held high restarts after one idle cycle.
module uart_tx_unit
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ       = UART_CLK_HZ,
   parameter int unsigned BIT_RATE     = UART_BIT_RATE,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
   input  logic                    uart_tx_en,
   output logic                    uart_txd,
   output logic                    uart_tx_busy
);

   localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT * STOP_BITS + 1);
   localparam int unsigned IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CYCLES_PER_BIT * STOP_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

   tx_state_e               state, state_nxt;
   logic [CNT_W-1:0]        cyc_cnt, cyc_cnt_nxt;
   logic [IDX_W-1:0]        bit_idx, bit_idx_nxt;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_nxt;
   logic                    txd_q, txd_nxt;
   logic                    busy_q, busy_nxt;

   // Line and busy are next-state registered so txd comes straight from a flop.
   always_comb begin
      state_nxt   = state;
      cyc_cnt_nxt = cyc_cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift_q;
      txd_nxt     = txd_q;
      busy_nxt    = busy_q;

      case (state)
         IDLE: begin
            txd_nxt  = 1'b1;
            busy_nxt = 1'b0;
            if (uart_tx_en) begin
               state_nxt   = START;
               shift_nxt   = uart_tx_data;
               cyc_cnt_nxt = '0;
               bit_idx_nxt = '0;
               txd_nxt     = 1'b0;
               busy_nxt    = 1'b1;
            end
         end

         START: begin
            if (cyc_cnt == BIT_LAST) begin
               state_nxt   = DATA;
               cyc_cnt_nxt = '0;
               bit_idx_nxt = '0;
               txd_nxt     = shift_q[0];
            end else begin
               cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (cyc_cnt == BIT_LAST) begin
               cyc_cnt_nxt = '0;
               if (bit_idx == IDX_LAST) begin
                  state_nxt = STOP;
                  txd_nxt   = 1'b1;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
                  shift_nxt   = shift_q >> 1;
                  txd_nxt     = shift_nxt[0];
               end
            end else begin
               cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
            end
         end

         STOP: begin
            txd_nxt = 1'b1;
            if (cyc_cnt == STOP_LAST) begin
               state_nxt   = IDLE;
               cyc_cnt_nxt = '0;
               busy_nxt    = 1'b0;
            end else begin
               cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt   = IDLE;
            cyc_cnt_nxt = '0;
            bit_idx_nxt = '0;
            txd_nxt     = 1'b1;
            busy_nxt    = 1'b0;
         end
      endcase
   end

   // Reset forces the line high directly, so an aborted frame never glitches low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cyc_cnt <= '0;
         bit_idx <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cyc_cnt <= cyc_cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift_q <= shift_nxt;
         txd_q   <= txd_nxt;
         busy_q  <= busy_nxt;
      end
   end

   assign uart_txd     = txd_q;
   assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: default-rate instance plus a 1 Mbaud instance (12 clocks per bit).
module tb_uart_tx_unit;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] uart_tx_data = 8'h00;
   logic       uart_tx_en = 1'b0;
   logic       uart_txd;
   logic       uart_tx_busy;

   logic [7:0] p_data = 8'h00;
   logic       p_en = 1'b0;
   logic       p_txd;
   logic       p_busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic txd_log   [0:3299];
   logic busy_log  [0:3299];
   logic p_log     [0:3299];
   logic pbusy_log [0:3299];

   always #5 clk = ~clk;

   uart_tx_unit dut (
      .clk          (clk),
      .resetn       (resetn),
      .uart_tx_data (uart_tx_data),
      .uart_tx_en   (uart_tx_en),
      .uart_txd     (uart_txd),
      .uart_tx_busy (uart_tx_busy)
   );

   uart_tx_unit #(
      .CLK_HZ   (12_000_000),
      .BIT_RATE (1_000_000)
   ) dut_fast (
      .clk          (clk),
      .resetn       (resetn),
      .uart_tx_data (p_data),
      .uart_tx_en   (p_en),
      .uart_txd     (p_txd),
      .uart_tx_busy (p_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample index 0 is the first falling edge after the edge that accepts en.
   task automatic capture(input int n, input int en_cycles, input int chg_at, input logic [7:0] chg_dat);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         txd_log[i]   = uart_txd;
         busy_log[i]  = uart_tx_busy;
         p_log[i]     = p_txd;
         pbusy_log[i] = p_busy;
         if (i + 1 == en_cycles) begin
            uart_tx_en = 1'b0;
            p_en       = 1'b0;
         end
         if (i == chg_at) uart_tx_data = chg_dat;
      end
   endtask

   task automatic check_frame(input string tag, input int start, input int cpb,
                              input logic [7:0] exp, input bit sel);
      int         bad;
      logic [7:0] dec;
      logic       eb;
      logic       v;
      bad = 0;
      dec = 8'h00;
      for (int b = 0; b < 10; b++) begin
         if (b == 0)      eb = 1'b0;
         else if (b == 9) eb = 1'b1;
         else             eb = exp[b-1];
         for (int k = 0; k < cpb; k++) begin
            v = sel ? p_log[start + b*cpb + k] : txd_log[start + b*cpb + k];
            if (v !== eb) bad++;
         end
         if (b >= 1 && b <= 8)
            dec[b-1] = sel ? p_log[start + b*cpb + cpb/2] : txd_log[start + b*cpb + cpb/2];
      end
      chk({tag, "_bad_samples"}, bad, 0);
      chk({tag, "_byte"}, {24'h0, dec}, {24'h0, exp});
   endtask

   function automatic int count_busy(input int n, input bit sel);
      int c;
      c = 0;
      for (int i = 0; i < n; i++)
         if ((sel ? pbusy_log[i] : busy_log[i]) === 1'b1) c++;
      return c;
   endfunction

   function automatic int count_low(input int from, input int to);
      int c;
      c = 0;
      for (int i = from; i < to; i++)
         if (txd_log[i] !== 1'b1) c++;
      return c;
   endfunction

   initial begin
      int  lows;
      int  busys;
      bit  idle_ok;

      // Reset hold
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_txd", {31'h0, uart_txd}, 32'd1);
         chk("rst_busy", {31'h0, uart_tx_busy}, 32'd0);
      end
      resetn = 1'b1;
      lows  = 0;
      busys = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (uart_txd !== 1'b1) lows++;
         if (uart_tx_busy !== 1'b0) busys++;
      end
      chk("idle_low_cycles", lows, 0);
      chk("idle_busy_cycles", busys, 0);

      // Single byte 0xA5, en held for 6 clocks
      @(negedge clk);
      uart_tx_data = 8'hA5;
      uart_tx_en   = 1'b1;
      capture(1200, 6, -1, 8'h00);
      chk("a5_first_txd", {31'h0, txd_log[0]}, 32'd0);
      chk("a5_first_busy", {31'h0, busy_log[0]}, 32'd1);
      check_frame("a5", 0, 104, 8'hA5, 1'b0);
      chk("a5_busy_len", count_busy(1200, 1'b0), 1040);
      chk("a5_busy_last", {31'h0, busy_log[1039]}, 32'd1);
      chk("a5_busy_drop", {31'h0, busy_log[1040]}, 32'd0);
      chk("a5_single_frame", count_low(1040, 1200), 0);

      // Data change mid-frame
      @(negedge clk);
      uart_tx_data = 8'h3C;
      uart_tx_en   = 1'b1;
      capture(1200, 1, 300, 8'hFF);
      check_frame("3c", 0, 104, 8'h3C, 1'b0);

      // Back-to-back with en held high
      @(negedge clk);
      uart_tx_data = 8'h55;
      uart_tx_en   = 1'b1;
      capture(3200, 100000, -1, 8'h00);
      uart_tx_en = 1'b0;
      check_frame("b2b_f0", 0, 104, 8'h55, 1'b0);
      chk("b2b_gap_txd", {31'h0, txd_log[1040]}, 32'd1);
      chk("b2b_gap_busy", {31'h0, busy_log[1040]}, 32'd0);
      chk("b2b_restart_busy", {31'h0, busy_log[1041]}, 32'd1);
      check_frame("b2b_f1", 1041, 104, 8'h55, 1'b0);
      check_frame("b2b_f2", 2082, 104, 8'h55, 1'b0);
      idle_ok = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (uart_tx_busy === 1'b0) begin
            idle_ok = 1'b1;
            break;
         end
      end
      chk("b2b_drain", {31'h0, idle_ok}, 32'd1);
      @(negedge clk);

      // Reset mid-frame, then a clean frame
      uart_tx_data = 8'h81;
      uart_tx_en   = 1'b1;
      capture(500, 1, -1, 8'h00);
      chk("mid_pre_txd", {31'h0, txd_log[499]}, 32'd0);
      chk("mid_pre_busy", {31'h0, busy_log[499]}, 32'd1);
      #1 resetn = 1'b0;
      #1;
      chk("mid_rst_txd", {31'h0, uart_txd}, 32'd1);
      chk("mid_rst_busy", {31'h0, uart_tx_busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      uart_tx_data = 8'hC3;
      uart_tx_en   = 1'b1;
      capture(1200, 1, -1, 8'h00);
      check_frame("post_rst", 0, 104, 8'hC3, 1'b0);
      chk("post_rst_busy_len", count_busy(1200, 1'b0), 1040);

      // 1 Mbaud instance: 12 clocks per bit, 120-clock frame
      @(negedge clk);
      p_data = 8'h01;
      p_en   = 1'b1;
      capture(200, 1, -1, 8'h00);
      check_frame("fast", 0, 12, 8'h01, 1'b1);
      chk("fast_busy_len", count_busy(200, 1'b1), 120);
      chk("fast_bit0_pre", {31'h0, p_log[11]}, 32'd0);
      chk("fast_bit0_first", {31'h0, p_log[12]}, 32'd1);
      chk("fast_bit0_last", {31'h0, p_log[23]}, 32'd1);
      chk("fast_bit1", {31'h0, p_log[24]}, 32'd0);
      chk("fast_idle_after", {31'h0, p_log[120]}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
